// File: rtl/antifurto_pkg.sv
// -----------------------------------------------------------------------------
// antifurto_pkg
//
// Shared constants for the anti-theft input path.
//
// Contents:
//   IDX_*           bit position of each conditioned input inside the
//                   raw_in / clean_out / rise_pulse / fall_pulse vectors
//   N_INPUTS_DEF    default channel count (one per IDX_* constant)
//   DEBOUNCE_SIM    short debounce window used in simulation
//   DEBOUNCE_BOARD  debounce window for hardware builds (mechanical bounce)
//   debounce_cnt_w  width of a counter that must hold 0..cycles-1
// -----------------------------------------------------------------------------
package antifurto_pkg;

  // Channel map. The anti-theft FSM consumes clean levels only; the
  // parameter-programming logic uses the rising edge of IDX_REPROGRAM.
  localparam int IDX_IGNITION    = 0;
  localparam int IDX_DOOR_DRIVER = 1;
  localparam int IDX_DOOR_PASS   = 2;
  localparam int IDX_REPROGRAM   = 3;
  localparam int IDX_BRAKE       = 4;
  localparam int IDX_HIDDEN_SW   = 5;

  localparam int N_INPUTS_DEF = 6;

  localparam int DEBOUNCE_SIM   = 4;
  localparam int DEBOUNCE_BOARD = 1_000_000;

  // The counter tops out at cycles-1, so $clog2(cycles+1) bits are always
  // enough and still give a 1-bit counter for cycles == 1.
  function automatic int debounce_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage : antifurto_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//
// One conditioned input: 2-flop synchronizer, stable-count debouncer and
// registered one-cycle edge pulses.
//
// Ports:
//   clock    in   system clock, rising-edge active
//   reset    in   asynchronous, active-high; loads RESET_LEVEL, clears counter
//                 and pulses
//   raw_i    in   asynchronous raw switch level
//   clean_o  out  debounced level
//   rise_o   out  one-cycle pulse on the edge where clean_o goes 0->1
//   fall_o   out  one-cycle pulse on the edge where clean_o goes 1->0
//
// Timing: a raw change that is stable before edge 1 appears on sync2 after
// edge 2 and on clean_o (with its pulse) after edge DEBOUNCE_CYCLES+2.
// -----------------------------------------------------------------------------
module debounce_channel
  import antifurto_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_SIM,
  parameter int   CNT_W           = debounce_cnt_w(DEBOUNCE_CYCLES),
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  // Counter value on the edge that commits a new level: the mismatch has
  // then been seen on DEBOUNCE_CYCLES consecutive edges.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;

  logic mismatch;
  logic terminal;

  assign mismatch = (sync2_q != clean_q);
  assign terminal = (cnt_q == CNT_TERM);

  // Any cycle where the synchronized input agrees with the clean level
  // restarts qualification from zero, so short glitches never accumulate.
  // The counter is cleared on the commit edge, so it never passes CNT_TERM.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!mismatch) begin
      cnt_d = '0;
    end else if (terminal) begin
      clean_d = sync2_q;
      cnt_d   = '0;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Reset loads the sync flops with RESET_LEVEL as well as clean_q, so the
  // first cycles after release see agreement and produce no spurious edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      clean_q <= RESET_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Conditions the raw switch/sensor inputs (ignition, door_driver, door_pass,
// reprogram, brake, hidden_sw) before they reach the anti-theft FSM and the
// fuel-pump logic. Each bit is an independent debounce_channel; channels do
// not interact, so simultaneous changes settle on the same edge when their
// timing matches.
//
// Parameters:
//   N_INPUTS         number of channels (default N_INPUTS_DEF)
//   DEBOUNCE_CYCLES  consecutive stable edges before clean_out changes (>= 1)
//   CNT_W            derived counter width; leave at its default
//   RESET_LEVEL      per-channel level loaded at reset
//
// Ports:
//   clock       in   system clock, rising-edge active
//   reset       in   asynchronous, active-high
//   raw_in      in   [N_INPUTS] asynchronous raw levels
//   clean_out   out  [N_INPUTS] debounced levels
//   rise_pulse  out  [N_INPUTS] one-cycle pulse on clean 0->1
//   fall_pulse  out  [N_INPUTS] one-cycle pulse on clean 1->0
// -----------------------------------------------------------------------------
module input_conditioner
  import antifurto_pkg::*;
#(
  parameter int                  N_INPUTS        = N_INPUTS_DEF,
  parameter int                  DEBOUNCE_CYCLES = DEBOUNCE_SIM,
  parameter int                  CNT_W           = debounce_cnt_w(DEBOUNCE_CYCLES),
  parameter logic [N_INPUTS-1:0] RESET_LEVEL     = {N_INPUTS{1'b0}}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] raw_in,
  output logic [N_INPUTS-1:0] clean_out,
  output logic [N_INPUTS-1:0] rise_pulse,
  output logic [N_INPUTS-1:0] fall_pulse
);

  // A zero-length window would commit on the first mismatching edge with a
  // counter that cannot be sized; refuse it at elaboration.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (raw_in[i]),
      .clean_o (clean_out[i]),
      .rise_o  (rise_pulse[i]),
      .fall_o  (fall_pulse[i])
    );
  end

endmodule : input_conditioner
